lfsr_arbiter: RTL and testbench
===============================

LFSR_ARBITER -- requirements
Module: lfsr_arbiter

Interface
REQ-001 Parameter N_REQ, default 4, number of requesters (2..8).
REQ-002 Parameter SEED, default 8'h01, LFSR value after reset; 8'h00 is replaced by 8'h01.
REQ-003 clk  input  1  rising-edge clock, sole clock.
REQ-004 rst_n  input  1  one clock; reset is synchronous and active-low.
REQ-005 req  input  N_REQ  per-requester request, level, held until granted.
REQ-006 seed_we  input  1  load seed into LFSR this cycle.
REQ-007 seed  input  8  seed value, sampled when seed_we=1.
REQ-008 gnt  output  N_REQ  registered one-hot grant, one-cycle pulse per issued value.
REQ-009 rnd  output  8  registered pseudo-random value, valid while |gnt=1; holds last value otherwise.
REQ-010 busy  output  1  registered; 1 when any unmasked request is pending.

Function
REQ-011 Internal 8-bit LFSR, polynomial x^8+x^6+x^5+x^4+1: next = {s[6:0], s[7]^s[5]^s[4]^s[3]}.
REQ-012 Eligible set in cycle t = req & ~gnt (requester granted in cycle t is masked for that cycle).
REQ-013 Round-robin: winner = first eligible index at or after ptr, wrapping N_REQ-1 -> 0; ptr = winner+1 mod N_REQ after each grant.
REQ-014 Latency: winner chosen in cycle t appears as gnt[winner]=1 with rnd = LFSR state at t, both in cycle t+1.
REQ-015 LFSR advances exactly once per grant issued; holds when no grant.
REQ-016 At most one gnt bit set per cycle; no eligible requester -> gnt=0, ptr and LFSR unchanged.
REQ-017 seed_we=1: LFSR <= (seed==0 ? 8'h01 : seed) next cycle; no grant decided that cycle; ptr unchanged; pending requests stay pending.
REQ-018 seed_we takes precedence over grant and lock in the same cycle.
REQ-019 Requester deasserting req before grant is dropped without side effects.
REQ-020 LFSR never reaches 8'h00 from any non-zero state; sequence period 255.
REQ-021 busy(t+1) = |(req(t) & ~gnt(t)).

Reset
REQ-022 rst_n=0 at a rising edge: gnt=0, rnd=8'h00, busy=0, ptr=0, LFSR=SEED (8'h01 if SEED=0), lock state cleared.
REQ-023 Reset mid-operation aborts any pending or locked grant; no gnt pulse in the cycle after reset is released unless req sampled in that first cycle.

Configuration
REQ-024 Macro LFSR_ARB_LOCK_EN, when defined, adds input lock (N_REQ bits) and burst grants.
REQ-025 With LFSR_ARB_LOCK_EN: if gnt[i]=1 and req[i]=1 and lock[i]=1 in cycle t, requester i is regranted in t+1 (overriding REQ-012 masking and round-robin), next LFSR value, up to 8 consecutive grants.
REQ-026 With LFSR_ARB_LOCK_EN: after the 8th consecutive grant, i is masked for one cycle and ptr = i+1; lock dropped earlier releases immediately.
REQ-027 Without LFSR_ARB_LOCK_EN: no lock port; behaviour is REQ-012..REQ-021 only.

Verification
REQ-028 Reset, SEED default, req=4'b0001 held -> gnt=0001 with rnd=01, 02, 04, 08 on alternate cycles (masking), gnt=0 between.
REQ-029 req=4'b1111 held from ptr=0 -> gnt sequence 0001,0010,0100,1000,0001 on consecutive cycles; rnd=01,02,04,08,11.
REQ-030 seed_we=1 seed=8'h00 with req=0010 pending -> no grant that cycle; next grant gnt=0010 rnd=01.
REQ-031 rst_n=0 while req=1111 mid-sequence -> next cycle gnt=0, rnd=00, busy=0; after release first grant is requester 0 with rnd=01.
REQ-032 Free-running grants, one requester: 255 grants return LFSR to 01 and 00 never observed on rnd.
REQ-033 LFSR_ARB_LOCK_EN, req=0011 lock=0001 -> requester 0 granted 8 consecutive cycles (rnd 01..), then gnt=0010 next.

Source files
------------

// File: rtl/lfsr_arbiter_if.sv
// Request/grant bundle for lfsr_arbiter; lock port exists only when LFSR_ARB_LOCK_EN is defined.
interface lfsr_arbiter_if #(
  parameter int unsigned N_REQ = 4
);
  logic [N_REQ-1:0] req;
  logic             seed_we;
  logic [7:0]       seed;
`ifdef LFSR_ARB_LOCK_EN
  logic [N_REQ-1:0] lock;
`endif
  logic [N_REQ-1:0] gnt;
  logic [7:0]       rnd;
  logic             busy;

  modport master (
    output req,
    output seed_we,
    output seed,
`ifdef LFSR_ARB_LOCK_EN
    output lock,
`endif
    input  gnt,
    input  rnd,
    input  busy
  );

  modport slave (
    input  req,
    input  seed_we,
    input  seed,
`ifdef LFSR_ARB_LOCK_EN
    input  lock,
`endif
    output gnt,
    output rnd,
    output busy
  );
endinterface

// File: rtl/lfsr_arbiter.sv
// Round-robin arbiter that tags each grant with an 8-bit LFSR value.
// Optional burst locking is enabled by defining LFSR_ARB_LOCK_EN.
module lfsr_arbiter #(
  parameter int unsigned N_REQ = 4,
  parameter logic [7:0]  SEED  = 8'h01
) (
  input  logic          clk,
  input  logic          rst_n,
  lfsr_arbiter_if.slave bus
);
  localparam int unsigned PTR_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [7:0]  SEED_EFF = (SEED == 8'h00) ? 8'h01 : SEED;

  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [7:0]       rnd_q, rnd_d;
  logic             busy_q, busy_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [7:0]       lfsr_q, lfsr_d;

  logic [7:0]       lfsr_nxt;
  logic [N_REQ-1:0] elig;
  logic             found;
  logic [PTR_W-1:0] win;
  logic [PTR_W-1:0] idx;

`ifdef LFSR_ARB_LOCK_EN
  logic [3:0]       burst_q, burst_d;
  logic             lock_hit;
`endif

  // Round-robin search from ptr over requesters not granted this cycle
  always_comb begin
    lfsr_nxt = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    elig     = bus.req & ~gnt_q;
    found    = 1'b0;
    win      = '0;
    idx      = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      idx = PTR_W'((32'(ptr_q) + k) % N_REQ);
      if (!found && elig[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  // Next-state: seed load beats lock, lock beats round-robin
  always_comb begin
    gnt_d  = '0;
    rnd_d  = rnd_q;
    busy_d = |(bus.req & ~gnt_q);
    ptr_d  = ptr_q;
    lfsr_d = lfsr_q;
`ifdef LFSR_ARB_LOCK_EN
    burst_d  = '0;
    lock_hit = (|(gnt_q & bus.req & bus.lock)) && (burst_q < 4'd8);
`endif
    if (bus.seed_we) begin
      lfsr_d = (bus.seed == 8'h00) ? 8'h01 : bus.seed;
`ifdef LFSR_ARB_LOCK_EN
    end else if (lock_hit) begin
      gnt_d   = gnt_q;
      rnd_d   = lfsr_q;
      lfsr_d  = lfsr_nxt;
      burst_d = burst_q + 4'd1;
`endif
    end else if (found) begin
      gnt_d      = '0;
      gnt_d[win] = 1'b1;
      rnd_d      = lfsr_q;
      lfsr_d     = lfsr_nxt;
      ptr_d      = PTR_W'((32'(win) + 32'd1) % N_REQ);
`ifdef LFSR_ARB_LOCK_EN
      burst_d    = 4'd1;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gnt_q   <= '0;
      rnd_q   <= 8'h00;
      busy_q  <= 1'b0;
      ptr_q   <= '0;
      lfsr_q  <= SEED_EFF;
`ifdef LFSR_ARB_LOCK_EN
      burst_q <= '0;
`endif
    end else begin
      gnt_q   <= gnt_d;
      rnd_q   <= rnd_d;
      busy_q  <= busy_d;
      ptr_q   <= ptr_d;
      lfsr_q  <= lfsr_d;
`ifdef LFSR_ARB_LOCK_EN
      burst_q <= burst_d;
`endif
    end
  end

  assign bus.gnt  = gnt_q;
  assign bus.rnd  = rnd_q;
  assign bus.busy = busy_q;
endmodule

// File: tb/tb_lfsr_arbiter.sv
// Directed, table-driven bench for lfsr_arbiter with hand-computed expectations.
module tb_lfsr_arbiter;
  logic clk = 1'b0;
  logic rst_n;
  int   n_total = 0;
  int   n_pass  = 0;

  lfsr_arbiter_if #(.N_REQ(4)) bus ();
  lfsr_arbiter #(.N_REQ(4), .SEED(8'h01)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    logic       rst_n;
    logic [3:0] req;
    logic       seed_we;
    logic [7:0] seed;
    logic [3:0] gnt;
    logic [7:0] rnd;
    logic       busy;
  } vec_t;

  vec_t vecs[25];

  function automatic vec_t v(logic r, logic [3:0] rq, logic sw, logic [7:0] sd,
                             logic [3:0] g, logic [7:0] rn, logic b);
    vec_t x;
    x.rst_n = r; x.req = rq; x.seed_we = sw; x.seed = sd;
    x.gnt = g; x.rnd = rn; x.busy = b;
    return x;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  initial begin
    // Alternating grants for a lone requester
    vecs[0]  = v(0, 4'b0000, 0, 8'h00, 4'b0000, 8'h00, 0);
    vecs[1]  = v(1, 4'b0001, 0, 8'h00, 4'b0001, 8'h01, 1);
    vecs[2]  = v(1, 4'b0001, 0, 8'h00, 4'b0000, 8'h01, 0);
    vecs[3]  = v(1, 4'b0001, 0, 8'h00, 4'b0001, 8'h02, 1);
    vecs[4]  = v(1, 4'b0001, 0, 8'h00, 4'b0000, 8'h02, 0);
    vecs[5]  = v(1, 4'b0001, 0, 8'h00, 4'b0001, 8'h04, 1);
    vecs[6]  = v(1, 4'b0001, 0, 8'h00, 4'b0000, 8'h04, 0);
    vecs[7]  = v(1, 4'b0001, 0, 8'h00, 4'b0001, 8'h08, 1);
    vecs[8]  = v(1, 4'b0000, 0, 8'h00, 4'b0000, 8'h08, 0);
    // All requesting: rotating grants
    vecs[9]  = v(0, 4'b1111, 0, 8'h00, 4'b0000, 8'h00, 0);
    vecs[10] = v(1, 4'b1111, 0, 8'h00, 4'b0001, 8'h01, 1);
    vecs[11] = v(1, 4'b1111, 0, 8'h00, 4'b0010, 8'h02, 1);
    vecs[12] = v(1, 4'b1111, 0, 8'h00, 4'b0100, 8'h04, 1);
    vecs[13] = v(1, 4'b1111, 0, 8'h00, 4'b1000, 8'h08, 1);
    vecs[14] = v(1, 4'b1111, 0, 8'h00, 4'b0001, 8'h11, 1);
    // Reset mid-sequence, then first grant restarts at requester 0
    vecs[15] = v(0, 4'b1111, 0, 8'h00, 4'b0000, 8'h00, 0);
    vecs[16] = v(1, 4'b1111, 0, 8'h00, 4'b0001, 8'h01, 1);
    // Zero seed load suppresses the grant and becomes 01
    vecs[17] = v(1, 4'b0010, 1, 8'h00, 4'b0000, 8'h01, 1);
    vecs[18] = v(1, 4'b0010, 0, 8'h00, 4'b0010, 8'h01, 1);
    vecs[19] = v(1, 4'b0000, 0, 8'h00, 4'b0000, 8'h01, 0);
    // Non-zero seed, dropped request, pointer wrap
    vecs[20] = v(1, 4'b0100, 1, 8'hA5, 4'b0000, 8'h01, 1);
    vecs[21] = v(1, 4'b0100, 0, 8'h00, 4'b0100, 8'hA5, 1);
    vecs[22] = v(1, 4'b1001, 0, 8'h00, 4'b1000, 8'h4A, 1);
    vecs[23] = v(1, 4'b1001, 0, 8'h00, 4'b0001, 8'h95, 1);
    vecs[24] = v(1, 4'b0000, 0, 8'h00, 4'b0000, 8'h95, 0);

    rst_n = 1'b0; bus.req = '0; bus.seed_we = 1'b0; bus.seed = 8'h00;
`ifdef LFSR_ARB_LOCK_EN
    bus.lock = '0;
`endif
    for (int i = 0; i < 25; i++) begin
      rst_n = vecs[i].rst_n; bus.req = vecs[i].req;
      bus.seed_we = vecs[i].seed_we; bus.seed = vecs[i].seed;
      @(negedge clk);
      chk($sformatf("v%0d_gnt", i),  32'(bus.gnt),  32'(vecs[i].gnt));
      chk($sformatf("v%0d_rnd", i),  32'(bus.rnd),  32'(vecs[i].rnd));
      chk($sformatf("v%0d_busy", i), 32'(bus.busy), 32'(vecs[i].busy));
    end

    // Full LFSR period with one requester
    begin
      bit   seen[256];
      int   grants = 0;
      int   distinct = 0;
      int   zeros = 0;
      int   cyc = 0;
      logic [7:0] last = 8'h00;
      rst_n = 1'b0; bus.req = '0; bus.seed_we = 1'b0;
      @(negedge clk);
      rst_n = 1'b1; bus.req = 4'b0001;
      while (grants < 256 && cyc < 1000) begin
        @(negedge clk);
        cyc++;
        if (bus.gnt == 4'b0001) begin
          grants++;
          last = bus.rnd;
          if (bus.rnd == 8'h00) zeros++;
          if (grants <= 255 && !seen[bus.rnd]) begin
            seen[bus.rnd] = 1'b1;
            distinct++;
          end
        end
      end
      chk("period_grants", 32'(grants), 32'd256);
      chk("period_distinct", 32'(distinct), 32'd255);
      chk("period_zero_seen", 32'(zeros), 32'd0);
      chk("period_wrap_rnd", 32'(last), 32'h01);
    end

`ifdef LFSR_ARB_LOCK_EN
    // Burst of 8 to locked requester 0, then requester 1
    begin
      logic [7:0] exp_rnd[9];
      exp_rnd = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h11, 8'h23, 8'h47, 8'h8E, 8'h1C};
      rst_n = 1'b0; bus.req = '0; bus.lock = '0;
      @(negedge clk);
      rst_n = 1'b1; bus.req = 4'b0011; bus.lock = 4'b0001;
      for (int i = 0; i < 9; i++) begin
        @(negedge clk);
        chk($sformatf("lock%0d_gnt", i), 32'(bus.gnt), (i < 8) ? 32'h1 : 32'h2);
        chk($sformatf("lock%0d_rnd", i), 32'(bus.rnd), 32'(exp_rnd[i]));
      end
      bus.req = '0; bus.lock = '0;
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
